// File: rtl/seven_segment_scan_decoder.sv
// Receive-side decoder for a scanned 4-digit seven-segment display: debounces each slot,
// decodes glyphs and publishes whole frames. Define SEVEN_SEGMENT_HEX_EN to accept A-F glyphs.
module seven_segment_scan_decoder #(
    parameter int SETTLE_N  = 4,
    parameter int TIMEOUT_N = 65536,
    parameter int STABLE_N  = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [3:0]  an_i,
    input  logic [6:0]  seven_segment_i,
    input  logic        dp_i,
    output logic [15:0] digits_o,
    output logic [3:0]  dp_o,
    output logic [3:0]  blank_o,
    output logic        frame_valid_o,
    output logic        stable_o,
    output logic        seg_err_o,
    output logic        an_err_o,
    output logic        timeout_o,
    input  logic        clear_err_i
);
    localparam int SW = $clog2(SETTLE_N + 1);
    localparam int TW = $clog2(TIMEOUT_N + 1);
    localparam int MW = $clog2(STABLE_N + 1);
    localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_N);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_N);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_N - 1);
    localparam logic [MW-1:0] MATCH_MAX    = MW'(STABLE_N - 1);

    // Result packing: {illegal, blank, code[3:0]}; segments are active-low {g,f,e,d,c,b,a}.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'h40:   res = {1'b0, 1'b0, 4'h0};
            7'h79:   res = {1'b0, 1'b0, 4'h1};
            7'h24:   res = {1'b0, 1'b0, 4'h2};
            7'h30:   res = {1'b0, 1'b0, 4'h3};
            7'h19:   res = {1'b0, 1'b0, 4'h4};
            7'h12:   res = {1'b0, 1'b0, 4'h5};
            7'h02:   res = {1'b0, 1'b0, 4'h6};
            7'h78:   res = {1'b0, 1'b0, 4'h7};
            7'h00:   res = {1'b0, 1'b0, 4'h8};
            7'h10:   res = {1'b0, 1'b0, 4'h9};
            7'h7F:   res = {1'b0, 1'b1, 4'h0};
`ifdef SEVEN_SEGMENT_HEX_EN
            7'h08:   res = {1'b0, 1'b0, 4'hA};
            7'h03:   res = {1'b0, 1'b0, 4'hB};
            7'h46:   res = {1'b0, 1'b0, 4'hC};
            7'h21:   res = {1'b0, 1'b0, 4'hD};
            7'h06:   res = {1'b0, 1'b0, 4'hE};
            7'h0E:   res = {1'b0, 1'b0, 4'hF};
`endif
            default: res = {1'b1, 1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic [3:0]    an_r, an_prev_r;
    logic [6:0]    seg_r, seg_prev_r;
    logic          dp_r, dp_prev_r;
    logic [SW-1:0] settle_r;
    logic [3:0]    mask_r;
    logic [15:0]   shadow_digits_r;
    logic [3:0]    shadow_dp_r, shadow_blank_r;
    logic [TW-1:0] tcnt_r;
    logic [MW-1:0] match_r;
    logic          have_prev_r;
    logic [15:0]   digits_r;
    logic [3:0]    dp_out_r, blank_r;
    logic          frame_valid_r, stable_r, seg_err_r, an_err_r, timeout_r;

    logic          single_s, multi_s, same_s, capture_s, publish_s, expire_s, frame_match_s;
    logic [1:0]    slot_s;
    logic [3:0]    cap_mask_s;
    logic [5:0]    dec_s;
    logic [SW-1:0] settle_next_s;
    logic [MW-1:0] match_next_s;

    // Slot classification, settle tracking and publish/timeout decisions on the sampled inputs.
    always_comb begin
        single_s = 1'b1;
        slot_s   = 2'd0;
        case (an_r)
            4'b1110: slot_s = 2'd0;
            4'b1101: slot_s = 2'd1;
            4'b1011: slot_s = 2'd2;
            4'b0111: slot_s = 2'd3;
            default: begin
                slot_s   = 2'd0;
                single_s = 1'b0;
            end
        endcase
        multi_s    = (!single_s) && (an_r != 4'hF);
        same_s     = ({an_r, seg_r, dp_r} == {an_prev_r, seg_prev_r, dp_prev_r});
        cap_mask_s = ~an_r;
        dec_s      = decode_seg(seg_r);

        if (!single_s) begin
            settle_next_s = {SW{1'b0}};
        end else if (!same_s) begin
            settle_next_s = SW'(1'b1);
        end else if (settle_r == SETTLE_MAX) begin
            settle_next_s = settle_r;
        end else begin
            settle_next_s = settle_r + SW'(1'b1);
        end
        // A saturated counter on an unchanged pattern means this slot was already taken.
        capture_s = single_s && (settle_next_s == SETTLE_MAX) &&
                    !(same_s && (settle_r == SETTLE_MAX));

        publish_s = (mask_r == 4'hF);
        expire_s  = !capture_s && !publish_s && (mask_r != 4'h0) && (tcnt_r >= TIMEOUT_LAST);

        frame_match_s = ({shadow_digits_r, shadow_dp_r, shadow_blank_r} ==
                         {digits_r, dp_out_r, blank_r});
        if (have_prev_r && frame_match_s) begin
            if (match_r == MATCH_MAX) begin
                match_next_s = match_r;
            end else begin
                match_next_s = match_r + MW'(1'b1);
            end
        end else begin
            match_next_s = {MW{1'b0}};
        end
    end

    // Input sampling and per-slot settle counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            an_r       <= 4'hF;
            seg_r      <= 7'h7F;
            dp_r       <= 1'b1;
            an_prev_r  <= 4'hF;
            seg_prev_r <= 7'h7F;
            dp_prev_r  <= 1'b1;
            settle_r   <= {SW{1'b0}};
        end else begin
            an_r       <= an_i;
            seg_r      <= seven_segment_i;
            dp_r       <= dp_i;
            an_prev_r  <= an_r;
            seg_prev_r <= seg_r;
            dp_prev_r  <= dp_r;
            settle_r   <= settle_next_s;
        end
    end

    // Slot capture into the shadow frame, capture mask and inactivity timer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mask_r          <= 4'h0;
            shadow_digits_r <= 16'h0000;
            shadow_dp_r     <= 4'h0;
            shadow_blank_r  <= 4'h0;
            tcnt_r          <= {TW{1'b0}};
        end else begin
            if (capture_s) begin
                shadow_digits_r[{slot_s, 2'b00} +: 4] <= dec_s[3:0];
                shadow_dp_r[slot_s]                   <= ~dp_r;
                shadow_blank_r[slot_s]                <= dec_s[4];
            end
            if (publish_s) begin
                mask_r <= capture_s ? cap_mask_s : 4'h0;
            end else if (expire_s) begin
                mask_r <= 4'h0;
            end else if (capture_s) begin
                mask_r <= mask_r | cap_mask_s;
            end else begin
                mask_r <= mask_r;
            end
            if (capture_s) begin
                tcnt_r <= {TW{1'b0}};
            end else if (tcnt_r != TIMEOUT_MAX) begin
                tcnt_r <= tcnt_r + TW'(1'b1);
            end else begin
                tcnt_r <= tcnt_r;
            end
        end
    end

    // Frame publish and stability tracking.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            digits_r      <= 16'h0000;
            dp_out_r      <= 4'h0;
            blank_r       <= 4'h0;
            frame_valid_r <= 1'b0;
            stable_r      <= 1'b0;
            match_r       <= {MW{1'b0}};
            have_prev_r   <= 1'b0;
        end else if (publish_s) begin
            digits_r      <= shadow_digits_r;
            dp_out_r      <= shadow_dp_r;
            blank_r       <= shadow_blank_r;
            frame_valid_r <= 1'b1;
            match_r       <= match_next_s;
            stable_r      <= (match_next_s == MATCH_MAX);
            have_prev_r   <= 1'b1;
        end else begin
            frame_valid_r <= 1'b0;
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            seg_err_r <= 1'b0;
            an_err_r  <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            if (capture_s && dec_s[5]) begin
                seg_err_r <= 1'b1;
            end else if (clear_err_i) begin
                seg_err_r <= 1'b0;
            end else begin
                seg_err_r <= seg_err_r;
            end
            if (multi_s) begin
                an_err_r <= 1'b1;
            end else if (clear_err_i) begin
                an_err_r <= 1'b0;
            end else begin
                an_err_r <= an_err_r;
            end
            if (expire_s) begin
                timeout_r <= 1'b1;
            end else if (clear_err_i) begin
                timeout_r <= 1'b0;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign digits_o      = digits_r;
    assign dp_o          = dp_out_r;
    assign blank_o       = blank_r;
    assign frame_valid_o = frame_valid_r;
    assign stable_o      = stable_r;
    assign seg_err_o     = seg_err_r;
    assign an_err_o      = an_err_r;
    assign timeout_o     = timeout_r;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: directed and random scans checked against a frame-level model.
module tb_seven_segment_scan_decoder;
    localparam int SETTLE_N  = 4;
    localparam int TIMEOUT_N = 100;
    localparam int STABLE_N  = 2;
    localparam int BLANK     = 16;

    logic        clk = 1'b0;
    logic        reset_i, dp_i, clear_err_i;
    logic [3:0]  an_i;
    logic [6:0]  seven_segment_i;
    logic [15:0] digits_o;
    logic [3:0]  dp_o, blank_o;
    logic        frame_valid_o, stable_o, seg_err_o, an_err_o, timeout_o;

    always #5 clk = ~clk;

    seven_segment_scan_decoder #(
        .SETTLE_N (SETTLE_N),
        .TIMEOUT_N(TIMEOUT_N),
        .STABLE_N (STABLE_N)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .an_i           (an_i),
        .seven_segment_i(seven_segment_i),
        .dp_i           (dp_i),
        .digits_o       (digits_o),
        .dp_o           (dp_o),
        .blank_o        (blank_o),
        .frame_valid_o  (frame_valid_o),
        .stable_o       (stable_o),
        .seg_err_o      (seg_err_o),
        .an_err_o       (an_err_o),
        .timeout_o      (timeout_o),
        .clear_err_i    (clear_err_i)
    );

    int cyc = 0;
    int pub_count = 0;
    int pub_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_valid_o === 1'b1) begin
            pub_count <= pub_count + 1;
            pub_cyc   <= cyc;
        end
    end

    int errors = 0;
    int checks = 0;
    int exp_pub = 0;
    int drive_cyc = 0;
    logic m_seg_err = 1'b0;
    int code_q [4];
    logic [3:0] dpl_q;
    logic [23:0] hist [$];
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int c);
        if (c == BLANK) return 7'h7F;
        return seg_tab[c];
    endfunction

    function automatic logic hex_en();
`ifdef SEVEN_SEGMENT_HEX_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_slot(input int k, input logic [6:0] seg, input logic dp_n, input int n);
        an_i            = ~(4'b0001 << k);
        seven_segment_i = seg;
        dp_i            = dp_n;
        drive_cyc       = cyc;
        repeat (n) tick();
    endtask

    task automatic gap();
        an_i            = 4'hF;
        seven_segment_i = 7'h7F;
        dp_i            = 1'b1;
        tick();
    endtask

    task automatic scan_frame();
        for (int k = 3; k >= 0; k--) begin
            drive_slot(k, seg_of(code_q[k]), ~dpl_q[k], 8);
            gap();
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) tick();
        reset_i = 1'b0;
        tick();
        hist.delete();
        m_seg_err = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".digits"}, digits_o, 32'h0);
        chk({tag, ".dp"}, dp_o, 32'h0);
        chk({tag, ".blank"}, blank_o, 32'h0);
        chk({tag, ".fv"}, frame_valid_o, 32'h0);
        chk({tag, ".stable"}, stable_o, 32'h0);
        chk({tag, ".seg_err"}, seg_err_o, 32'h0);
        chk({tag, ".an_err"}, an_err_o, 32'h0);
        chk({tag, ".timeout"}, timeout_o, 32'h0);
    endtask

    // Expected frame from the scanned codes; stability from the published-frame history.
    task automatic expect_frame(input string tag);
        logic [15:0] d;
        logic [3:0]  b;
        logic        st;
        int          n;
        d = 16'h0000;
        b = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (code_q[k] == BLANK) begin
                b[k] = 1'b1;
            end else if (code_q[k] >= 10 && !hex_en()) begin
                m_seg_err = 1'b1;
            end else begin
                d[k*4 +: 4] = 4'(code_q[k]);
            end
        end
        hist.push_back({d, dpl_q, b});
        exp_pub++;
        n  = hist.size();
        st = (n >= STABLE_N);
        for (int i = 1; i < STABLE_N && st; i++) begin
            if (hist[n-1-i] != hist[n-1]) st = 1'b0;
        end
        for (int i = 0; i < 20 && pub_count < exp_pub; i++) tick();
        chk({tag, ".publishes"}, pub_count, exp_pub);
        chk({tag, ".digits"}, digits_o, {16'h0, d});
        chk({tag, ".dp"}, dp_o, {28'h0, dpl_q});
        chk({tag, ".blank"}, blank_o, {28'h0, b});
        chk({tag, ".stable"}, stable_o, {31'h0, st});
        chk({tag, ".seg_err"}, seg_err_o, {31'h0, m_seg_err});
    endtask

    initial begin
        int t0;
        int p0;
        an_i            = 4'hF;
        seven_segment_i = 7'h7F;
        dp_i            = 1'b1;
        clear_err_i     = 1'b0;
        do_reset();
        check_zero("reset");

        // Normal scan 1,2,3,4 with publish latency from the last slot's first drive.
        code_q = '{4, 3, 2, 1};
        dpl_q  = 4'b0000;
        scan_frame();
        expect_frame("normal");
        chk("normal.const", digits_o, 32'h1234);
        chk("normal.latency", pub_cyc, drive_cyc + 1 + SETTLE_N + 1);

        // Slot1 glitches on '0' for 3 cycles before settling on '1' with dp lit.
        code_q = '{7, 1, 6, 5};
        dpl_q  = 4'b0010;
        drive_slot(3, seg_of(5), 1'b1, 8); gap();
        drive_slot(2, seg_of(6), 1'b1, 8); gap();
        drive_slot(1, 7'h40, 1'b1, 3);
        drive_slot(1, seg_of(1), 1'b0, 8); gap();
        drive_slot(0, seg_of(7), 1'b1, 8); gap();
        expect_frame("glitch");
        chk("glitch.const", digits_o, 32'h5617);
        chk("glitch.dpconst", dp_o, 32'h2);

        // Repeated frames become stable; a changed digit drops stability.
        code_q = '{4, 3, 2, 1};
        dpl_q  = 4'b0000;
        scan_frame(); expect_frame("stab1"); chk("stab1.const", stable_o, 32'h0);
        scan_frame(); expect_frame("stab2"); chk("stab2.const", stable_o, 32'h1);
        scan_frame(); expect_frame("stab3"); chk("stab3.const", stable_o, 32'h1);
        code_q[0] = 5;
        scan_frame(); expect_frame("stab4"); chk("stab4.const", stable_o, 32'h0);

        // Random frames, sometimes repeating the previous one.
        for (int f = 0; f < 6; f++) begin
            if (f == 0 || $urandom_range(0, 2) != 0) begin
                for (int k = 0; k < 4; k++) begin
                    code_q[k] = $urandom_range(0, 10);
                    if (code_q[k] == 10) code_q[k] = BLANK;
                end
                dpl_q = 4'($urandom_range(0, 15));
            end
            scan_frame();
            expect_frame("random");
        end

        // Anode and segment errors, clear, then set-wins-over-clear.
        an_i = 4'b1100; tick();
        an_i = 4'hF; tick(); tick();
        chk("an_err.set", an_err_o, 32'h1);
        drive_slot(2, 7'h55, 1'b1, 8); gap();
        chk("seg_err.set", seg_err_o, 32'h1);
        clear_err_i = 1'b1; tick();
        clear_err_i = 1'b0;
        chk("clear.an_err", an_err_o, 32'h0);
        chk("clear.seg_err", seg_err_o, 32'h0);
        an_i = 4'b1100; tick();
        an_i = 4'hF; clear_err_i = 1'b1; tick();
        clear_err_i = 1'b0;
        chk("setwins.an_err", an_err_o, 32'h1);
        tick();
        chk("setwins.hold", an_err_o, 32'h1);
        do_reset();
        check_zero("reset2");

        // Partial frame expires exactly TIMEOUT_N cycles after the last capture.
        drive_slot(0, seg_of(9), 1'b1, 8); gap();
        drive_slot(1, seg_of(9), 1'b1, 8);
        t0 = drive_cyc;
        gap();
        repeat (t0 + 1 + SETTLE_N + TIMEOUT_N - 2 - cyc) tick();
        chk("timeout.before", timeout_o, 32'h0);
        repeat (2) tick();
        chk("timeout.set", timeout_o, 32'h1);
        code_q = '{8, 7, 6, 5};
        dpl_q  = 4'b0000;
        scan_frame();
        expect_frame("after_timeout");
        chk("after_timeout.flag", timeout_o, 32'h1);
        clear_err_i = 1'b1; tick();
        clear_err_i = 1'b0;
        chk("timeout.clear", timeout_o, 32'h0);

        // Hex glyph 'A' on slot2: legal only with the hex option.
        code_q = '{3, 2, 10, 1};
        scan_frame();
        expect_frame("hex");
        chk("hex.nibble2", digits_o[11:8], hex_en() ? 32'hA : 32'h0);

        // Reset after two captures discards them; publish needs four fresh slots.
        drive_slot(1, seg_of(9), 1'b1, 8); gap();
        drive_slot(0, seg_of(9), 1'b1, 8); gap();
        do_reset();
        check_zero("reset3");
        p0 = pub_count;
        code_q = '{7, 6, 5, 4};
        drive_slot(3, seg_of(4), 1'b1, 8); gap();
        drive_slot(2, seg_of(5), 1'b1, 8); gap();
        repeat (3) tick();
        chk("reset3.no_publish", pub_count, p0);
        drive_slot(1, seg_of(6), 1'b1, 8); gap();
        drive_slot(0, seg_of(7), 1'b1, 8); gap();
        expect_frame("post_reset");
        chk("post_reset.const", digits_o, 32'h4567);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
